// File: rtl/porta_bus_master.sv
// Z80 bus-takeover sequencer: borrows the bus via BUSREQn/BUSACKn and
// performs a single-byte write or a 1-256 byte incrementing read burst.
module porta_bus_master #(
  parameter int ACCESS_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  cmd_wdata,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic        BUSREQn,
  input  logic        BUSACKn,
  input  logic        WAITn,
  output logic        BUS_OE,
  output logic [15:0] A_OUT,
  output logic        MREQn_OUT,
  output logic        RDn_OUT,
  output logic        WRn_OUT,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic [7:0]  D_IN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE
  } state_e;

  localparam logic [15:0] ACC_LAST = 16'(ACCESS_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        init_q, init_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [8:0]  rem_q, rem_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bus_act;

  // init_q keeps cmd_ready low while reset is held
  assign cmd_ready = (state_q == S_IDLE) & init_q & BUSACKn;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write)
            rem_d = 9'd1;
          else if (cmd_len == 8'd0)
            rem_d = 9'd256;
          else
            rem_d = {1'b0, cmd_len};
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!BUSACKn) begin
          acc_d   = '0;
          state_d = S_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_SETUP: begin
        acc_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        // clocks with WAITn low stretch the strobe without counting
        if (WAITn) begin
          if (acc_q == ACC_LAST) begin
            if (!wr_q)
              rdata_d = D_IN;
            state_d = S_HOLD;
          end else begin
            acc_d = acc_q + 16'd1;
          end
        end
      end
      S_HOLD: begin
        rem_d = rem_q - 9'd1;
        if (rem_q == 9'd1) begin
          state_d = S_RELEASE;
        end else begin
          addr_d  = addr_q + 16'd1;
          state_d = S_SETUP;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_act = (state_q == S_SETUP)
                 | (state_q == S_STROBE)
                 | (state_q == S_HOLD);

  assign BUSREQn   = ~(bus_act | (state_q == S_REQ));
  assign BUS_OE    = bus_act;
  assign A_OUT     = addr_q;
  assign MREQn_OUT = ~(state_q == S_STROBE);
  assign RDn_OUT   = ~((state_q == S_STROBE) & ~wr_q);
  assign WRn_OUT   = ~((state_q == S_STROBE) & wr_q);
  assign D_OE      = bus_act & wr_q;
  assign D_OUT     = wdata_q;
  assign rd_valid  = (state_q == S_HOLD) & ~wr_q;
  assign rd_data   = rdata_q;
  assign done      = (state_q == S_RELEASE);
  assign err       = err_q;

endmodule

// File: tb/tb_porta_bus_master.sv
// Scoreboard bench for porta_bus_master with a simple Z80 BUSACKn
// responder and an address-derived memory model on D_IN.
module tb_porta_bus_master;

  logic        clk = 1'b0;
  logic        RESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        done;
  logic        err;
  logic        BUSREQn;
  logic        BUSACKn = 1'b1;
  logic        WAITn = 1'b1;
  logic        BUS_OE;
  logic [15:0] A_OUT;
  logic        MREQn_OUT;
  logic        RDn_OUT;
  logic        WRn_OUT;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN;

  logic        pat_mode = 1'b0;
  logic [7:0]  din_v = '0;
  logic        ack_en = 1'b1;
  logic        req_d1 = 1'b1;

  porta_bus_master #(
    .ACCESS_CYCLES(3),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .RESETn(RESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .BUSREQn(BUSREQn), .BUSACKn(BUSACKn), .WAITn(WAITn),
    .BUS_OE(BUS_OE), .A_OUT(A_OUT),
    .MREQn_OUT(MREQn_OUT), .RDn_OUT(RDn_OUT), .WRn_OUT(WRn_OUT),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign D_IN = pat_mode ? pat(A_OUT) : din_v;

  // Z80 acknowledges two clocks after BUSREQn changes
  always @(posedge clk) begin
    req_d1  <= BUSREQn;
    BUSACKn <= ack_en ? req_d1 : 1'b1;
  end

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0, oe_cyc = 0, doe_cyc = 0, dout_bad = 0;
  int rd_low = 0, wr_low = 0, cur_len = 0, last_len = 0;
  int rd_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] exp_wdata = '0;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!BUS_OE && (!MREQn_OUT || !RDn_OUT || !WRn_OUT || D_OE))
        viol++;
      if (BUS_OE) oe_cyc++;
      if (D_OE) begin
        doe_cyc++;
        if (D_OUT !== exp_wdata) dout_bad++;
      end
      if (!RDn_OUT) rd_low++;
      if (!WRn_OUT) wr_low++;
      if (!MREQn_OUT) cur_len++;
      else if (cur_len != 0) begin
        last_len = cur_len;
        cur_len = 0;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (rd_valid) begin
        rd_cnt++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_spurious: got A=%h D=%h, required no rd_valid",
                   A_OUT, rd_data);
        end else begin
          e = q.pop_front();
          if (A_OUT !== e.a || rd_data !== e.d) begin
            n_fail++;
            $display("FAIL rd_byte: got A=%h D=%h, required A=%h D=%h",
                     A_OUT, rd_data, e.a, e.d);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic issue(input bit wr, input logic [15:0] a,
                       input logic [7:0] len, input logic [7:0] wd);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 200 clks",
               cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = len;
      cmd_wdata = wd;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_end(input int budget, output bit gd,
                          output bit ge, output logic rq);
    gd = 0;
    ge = 0;
    rq = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        gd = 1;
        rq = BUSREQn;
        break;
      end
      if (err) begin
        ge = 1;
        break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({BUSREQn, MREQn_OUT, RDn_OUT, WRn_OUT, BUS_OE, D_OE,
         rd_valid, done, err, cmd_ready} !== 10'b1111_000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 1111000000",
               {BUSREQn, MREQn_OUT, RDn_OUT, WRn_OUT, BUS_OE, D_OE,
                rd_valid, done, err, cmd_ready});
    end
    n_checks++;
    if ({A_OUT, D_OUT, rd_data} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got A=%h DO=%h RD=%h, required zeros",
               A_OUT, D_OUT, rd_data);
    end
    RESETn = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_read1();
    int rd0, dn0, rl0;
    bit gd, ge;
    logic rq;
    rd0 = rd_cnt; dn0 = done_cnt; rl0 = rd_low;
    pat_mode = 1'b0;
    din_v = 8'hA5;
    push_exp(16'h6000, 8'hA5);
    issue(1'b0, 16'h6000, 8'd1, 8'h00);
    n_checks++;
    if (BUSREQn !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read1_req: got BUSREQn=%b cmd_ready=%b, required 0 0",
               BUSREQn, cmd_ready);
    end
    wait_end(100, gd, ge, rq);
    n_checks++;
    if (!gd || ge || rq !== 1'b1) begin
      n_fail++;
      $display("FAIL read1_done: got done=%b err=%b BUSREQn=%b, required 1 0 1",
               gd, ge, rq);
    end
    n_checks++;
    if (last_len != 3 || rd_low - rl0 != 3) begin
      n_fail++;
      $display("FAIL read1_strobe: got mreq=%0d rd=%0d clks, required 3 3",
               last_len, rd_low - rl0);
    end
    n_checks++;
    if (rd_cnt - rd0 != 1 || done_cnt - dn0 != 1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL read1_count: got rd=%0d done=%0d left=%0d, required 1 1 0",
               rd_cnt - rd0, done_cnt - dn0, q.size());
    end
  endtask

  task automatic test_write();
    int rd0, dn0, rl0, wl0, do0, db0;
    bit gd, ge;
    logic rq;
    rd0 = rd_cnt; dn0 = done_cnt; rl0 = rd_low;
    wl0 = wr_low; do0 = doe_cyc; db0 = dout_bad;
    exp_wdata = 8'h3C;
    issue(1'b1, 16'h7FFF, 8'd7, 8'h3C);
    wait_end(100, gd, ge, rq);
    n_checks++;
    if (!gd || ge || rq !== 1'b1) begin
      n_fail++;
      $display("FAIL write_done: got done=%b err=%b BUSREQn=%b, required 1 0 1",
               gd, ge, rq);
    end
    n_checks++;
    if (wr_low - wl0 != 3 || rd_low - rl0 != 0) begin
      n_fail++;
      $display("FAIL write_strobe: got wr=%0d rd=%0d clks, required 3 0",
               wr_low - wl0, rd_low - rl0);
    end
    n_checks++;
    if (doe_cyc - do0 != 5 || dout_bad - db0 != 0) begin
      n_fail++;
      $display("FAIL write_data: got d_oe=%0d bad=%0d, required 5 0",
               doe_cyc - do0, dout_bad - db0);
    end
    n_checks++;
    if (done_cnt - dn0 != 1 || rd_cnt - rd0 != 0) begin
      n_fail++;
      $display("FAIL write_count: got done=%0d rd=%0d, required 1 0",
               done_cnt - dn0, rd_cnt - rd0);
    end
  endtask

  task automatic test_wait();
    bit gd, ge, seen;
    logic rq;
    pat_mode = 1'b0;
    din_v = 8'h11;
    push_exp(16'h1234, 8'h77);
    issue(1'b0, 16'h1234, 8'd1, 8'h00);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!MREQn_OUT) begin
        seen = 1;
        break;
      end
    end
    WAITn = 1'b0;
    repeat (4) @(negedge clk);
    WAITn = 1'b1;
    din_v = 8'h77;
    wait_end(100, gd, ge, rq);
    n_checks++;
    if (!seen || !gd || last_len != 7) begin
      n_fail++;
      $display("FAIL wait_stretch: got seen=%b done=%b len=%0d, required 1 1 7",
               seen, gd, last_len);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_count: got %0d bytes left, required 0", q.size());
    end
  endtask

  task automatic test_burst();
    int rd0, dn0;
    bit gd, ge;
    logic rq;
    logic [15:0] a;
    rd0 = rd_cnt; dn0 = done_cnt;
    pat_mode = 1'b1;
    a = 16'hFFFE;
    for (int i = 0; i < 256; i++) begin
      push_exp(a, pat(a));
      a = a + 16'd1;
    end
    issue(1'b0, 16'hFFFE, 8'd0, 8'h00);
    wait_end(2000, gd, ge, rq);
    n_checks++;
    if (!gd || ge || rq !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_done: got done=%b err=%b BUSREQn=%b, required 1 0 1",
               gd, ge, rq);
    end
    n_checks++;
    if (rd_cnt - rd0 != 256 || done_cnt - dn0 != 1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_count: got rd=%0d done=%0d left=%0d, required 256 1 0",
               rd_cnt - rd0, done_cnt - dn0, q.size());
    end
  endtask

  task automatic test_timeout();
    int oe0, dn0, er0, n;
    bit seen;
    logic rq1, rqe;
    oe0 = oe_cyc; dn0 = done_cnt; er0 = err_cnt;
    ack_en = 1'b0;
    repeat (3) @(posedge clk);
    issue(1'b1, 16'h4000, 8'd0, 8'h55);
    n = 0;
    seen = 0;
    rq1 = 1'bx;
    rqe = 1'bx;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) rq1 = BUSREQn;
      if (err) begin
        seen = 1;
        rqe = BUSREQn;
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (!seen || n != 10) begin
      n_fail++;
      $display("FAIL timeout_time: got err=%b after %0d clks, required 1 after 10",
               seen, n);
    end
    n_checks++;
    if (rq1 !== 1'b0 || rqe !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_req: got BUSREQn %b then %b, required 0 then 1",
               rq1, rqe);
    end
    n_checks++;
    if (oe_cyc - oe0 != 0 || done_cnt - dn0 != 0 || err_cnt - er0 != 1) begin
      n_fail++;
      $display("FAIL timeout_count: got oe=%0d done=%0d err=%0d, required 0 0 1",
               oe_cyc - oe0, done_cnt - dn0, err_cnt - er0);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int rd0, dn0, er0;
    bit seen;
    rd0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt;
    pat_mode = 1'b1;
    for (int i = 0; i < 4; i++)
      push_exp(16'h2000 + 16'(i), pat(16'h2000 + 16'(i)));
    issue(1'b0, 16'h2000, 8'd4, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt - rd0 >= 1) break;
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!MREQn_OUT) begin
        seen = 1;
        break;
      end
    end
    #2;
    RESETn = 1'b0;
    #1;
    n_checks++;
    if (!seen || {BUSREQn, MREQn_OUT, RDn_OUT, WRn_OUT, BUS_OE, D_OE}
                 !== 6'b111100) begin
      n_fail++;
      $display("FAIL rstmid_async: got seen=%b bus=%b, required 1 111100",
               seen, {BUSREQn, MREQn_OUT, RDn_OUT, WRn_OUT, BUS_OE, D_OE});
    end
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (rd_cnt - rd0 != 1 || done_cnt - dn0 != 0 || err_cnt - er0 != 0
        || q.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_drop: got rd=%0d done=%0d err=%0d left=%0d, required 1 0 0 3",
               rd_cnt - rd0, done_cnt - dn0, err_cnt - er0, q.size());
    end
    q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && BUSACKn === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_read1();
    test_write();
    test_wait();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_read1();
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL strobe_oe: got %0d strobe/D_OE clks without BUS_OE, required 0",
               viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/porta_bus_master.md
# porta_bus_master

Z80 bus-takeover sequencer for the portable ColecoVision glue CPLD. It lets an on-board auxiliary requester, such as a future serial debug/loader front end, borrow the system bus from the Z80. It requests the bus via BUSREQn/BUSACKn, performs a single-byte memory write or a 1–256 byte auto-incrementing memory read burst, then returns the bus to the CPU. Its memory strobes feed the same MREQn/RDn/WRn/A decode that generates ROM/RAM/cartridge chip selects.

## Interface
Parameters:
- ACCESS_CYCLES, 3: clocks MREQn+RDn/WRn are held low per byte (min 1).
- TIMEOUT_CYCLES, 255: max clocks waiting for BUSACKn before abort (min 1, ≤ 65535).

Ports:
- clk  in  1  system clock, same domain as the Z80; all logic on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = single-byte write, 0 = read burst.
- cmd_addr  in  16  start address.
- cmd_len  in  8  read burst length; 0 means 256; ignored for writes.
- cmd_wdata  in  8  write data.
- rd_valid  out  1  one-clock pulse, rd_data valid; no backpressure.
- rd_data  out  8  captured read byte.
- done  out  1  one-clock pulse, command finished, bus released.
- err  out  1  one-clock pulse, BUSACKn timeout, nothing accessed.
- BUSREQn  out  1  Z80 bus request.
- BUSACKn  in  1  Z80 bus acknowledge.
- WAITn  in  1  wait from memory/decode; low stretches the strobe.
- BUS_OE  out  1  enables top-level A/MREQn/RDn/WRn tristate drivers.
- A_OUT  out  16  address.
- MREQn_OUT, RDn_OUT, WRn_OUT  out  1 each  memory strobes.
- D_OUT  out  8  write data.
- D_OE  out  1  enables D_OUT onto D.
- D_IN  in  8  data bus read back.

## Operation
- States: IDLE, REQ, SETUP, STROBE, HOLD, RELEASE.
- IDLE: cmd_ready = BUSACKn (high only while the CPU owns the bus). On accept, latch cmd fields, remaining = (cmd_len==0 ? 256 : cmd_len), or 1 for a write, and go to REQ.
- REQ: BUSREQn=0; timeout counter increments each clock.
  - BUSACKn sampled low → SETUP.
  - Counter reaches TIMEOUT_CYCLES with BUSACKn still high → BUSREQn=1, err pulse, IDLE. No done pulse.
- SETUP (1 clk): BUS_OE=1, A_OUT=address, strobes high; for a write D_OE=1 and D_OUT=wdata.
- STROBE: MREQn_OUT=0 and RDn_OUT=0 (read) or WRn_OUT=0 (write); D_OE stays 1 for a write.
  - Hold for ACCESS_CYCLES clocks; each clock with WAITn low does not count.
  - Read: D_IN is captured into rd_data on the edge that exits STROBE.
- HOLD (1 clk): strobes high, address still driven, D_OE stays 1 for a write.
  - Read: rd_valid=1.
  - remaining decrements. If nonzero: address+1 (FFFF wraps to 0000), → SETUP. Else → RELEASE.
- RELEASE (1 clk): BUS_OE=0, D_OE=0, BUSREQn=1, done=1 → IDLE.
- A new command is not accepted until BUSACKn returns high.
- cmd_valid/cmd_* are ignored outside IDLE.

## Timing
- Reset values (asserted asynchronously, held while RESETn low): BUSREQn=1, MREQn_OUT=RDn_OUT=WRn_OUT=1, BUS_OE=0, D_OE=0, A_OUT=0, D_OUT=0, rd_data=0, rd_valid=done=err=0, cmd_ready=0, state IDLE. cmd_ready follows BUSACKn from the first clock after deassertion.
- Reset mid-operation: strobes, BUS_OE and BUSREQn release immediately (asynchronously); the in-flight command is dropped with no done or err.
- Strobes and D_OE are never active while BUS_OE=0. BUS_OE=1 only in SETUP, STROBE and HOLD.
- Single read, ACCESS_CYCLES=3, BUSACKn already low when sampled in REQ, accept at edge 0:
  - REQ is cycle 1; SETUP cycle 2; STROBE cycles 3–5; HOLD cycle 6 (rd_valid); RELEASE cycle 7 (done).
- Per-byte burst cost is 1 + ACCESS_CYCLES + 1 clocks plus WAITn stretch.
- Timeout: err fires TIMEOUT_CYCLES clocks after REQ entry.

## Test plan
- Read 1 byte at 0x6000, D_IN=0xA5, BUSACKn low 2 clks after BUSREQn → BUSREQn low at cycle 1, strobes low 3 clks, rd_valid with rd_data=0xA5, done, BUSREQn high.
- Write 0x3C to 0x7FFF → WRn_OUT low 3 clks, D_OE high SETUP through HOLD, D_OUT=0x3C, RDn_OUT stays high, single done.
- Read burst cmd_len=0 from 0xFFFE → 256 rd_valid pulses, addresses 0xFFFE, 0xFFFF, 0x0000…0x00FD, one done.
- WAITn low 4 clks during the first STROBE clock of a read → strobe 7 clks total, captured data is the D_IN present at STROBE exit.
- BUSACKn held high, TIMEOUT_CYCLES=10 → err at 10 clks, BUSREQn high, BUS_OE never asserted, no done.
- RESETn pulsed low during STROBE of a 4-byte burst → strobes, BUS_OE, BUSREQn inactive immediately, no further rd_valid/done, cmd_ready returns once BUSACKn high.
